text_scanner: RTL and testbench



---
 rtl/text_scanner.sv | 88 ++++++++
 tb/tb_text_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/text_scanner.sv
// text_scanner: VGA text-mode raster front end -- timing counters, text cell walk,
// glyph pixel colouring and a blinking block cursor, two pix_en steps of latency.
module text_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int COLS = H_ACTIVE / 8,
  parameter int ROWS = V_ACTIVE / 8,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [12:0] text_addr,
  input  logic [8:0]  text_data,
  output logic [8:0]  fm_char,
  output logic [8:0]  fm_xoffset,
  output logic [8:0]  fm_yoffset,
  input  logic        fm_bitmap,
  input  logic [7:0]  fg_color,
  input  logic [7:0]  bg_color,
  input  logic [12:0] cursor_pos,
  input  logic        cursor_en,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSE = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VSS = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSE = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [BLINK_LOG2:0] ONE = 1;
  logic [9:0] hcnt, vcnt;
  logic [BLINK_LOG2:0] fcnt;
  logic [2:0] xoff, yoff;
  logic vis1, hs1, vs1, cur1;
  logic vis0, hwrap, vwrap;
  assign vis0 = hcnt < HA && vcnt < VA;
  assign hwrap = hcnt == HL;
  assign vwrap = vcnt == VL;
  assign frame_start = rst_n && pix_en && hwrap && vwrap;
  assign text_addr = vis0 ? 13'(vcnt[9:3]) * 13'(COLS) + 13'(hcnt[9:3]) : 13'd0;
  assign fm_char = text_data;
  assign fm_xoffset = {6'b0, xoff};
  assign fm_yoffset = {6'b0, yoff};
  // sync flags reset to their inactive level so no spurious sync pulse follows reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      fcnt <= '0;
      xoff <= '0;
      yoff <= '0;
      vis1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      cur1 <= 1'b0;
      rgb <= 8'h00;
      active <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      hcnt <= hwrap ? 10'd0 : hcnt + 10'd1;
      if (hwrap) vcnt <= vwrap ? 10'd0 : vcnt + 10'd1;
      if (hwrap && vwrap) fcnt <= fcnt + ONE;
      xoff <= hcnt[2:0];
      yoff <= vcnt[2:0];
      vis1 <= vis0;
      hs1 <= !(hcnt >= HSS && hcnt < HSE);
      vs1 <= !(vcnt >= VSS && vcnt < VSE);
      cur1 <= cursor_en && vis0 && text_addr == cursor_pos;
      rgb <= vis1 ? ((fm_bitmap ^ (cur1 & fcnt[BLINK_LOG2])) ? fg_color : bg_color) : 8'h00;
      active <= vis1;
      hsync <= hs1;
      vsync <= vs1;
    end
endmodule

// File: tb/tb_text_scanner.sv
// tb_text_scanner: randomized pixel-step stimulus on a shrunken raster, checked against
// a position-level model of what each screen pixel should look like.
module tb_text_scanner;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int COLS = HA / 8, ROWS = VA / 8, BL = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  typedef struct {int h; int v; bit vis; bit hs; bit vs; bit hit;} cell_t;
  logic clk = 0, rst_n = 0, pix_en = 0, cursor_en = 0, fm_bitmap;
  logic [12:0] text_addr, cursor_pos = 0;
  logic [8:0] text_data = 0, fm_char, fm_xoffset, fm_yoffset;
  logic [7:0] fg_color = 8'hff, bg_color = 8'h00, rgb;
  logic hsync, vsync, active, frame_start;
  logic [8:0] mem [0:8191];
  int checks = 0, errors = 0;
  int ch, cv, fcount, frames, fs_seen, hrun, vrun;
  logic [8:0] ram_char;
  cell_t hold;
  logic [7:0] e_rgb;
  bit e_act, e_hs, e_vs;
  always #5 clk = ~clk;
  text_scanner #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                 .COLS(COLS), .ROWS(ROWS), .BLINK_LOG2(BL)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .text_addr(text_addr), .text_data(text_data),
    .fm_char(fm_char), .fm_xoffset(fm_xoffset), .fm_yoffset(fm_yoffset), .fm_bitmap(fm_bitmap),
    .fg_color(fg_color), .bg_color(bg_color), .cursor_pos(cursor_pos), .cursor_en(cursor_en),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start));
  always @(posedge clk) text_data <= mem[text_addr];
  function automatic logic glyph_bit(logic [8:0] c, logic [2:0] x, logic [2:0] y);
    logic [63:0] a = 64'h183C66667E666600;
    logic [7:0] row = (c == 9'h041) ? a[63 - 8 * y -: 8] : 8'(c * 37) ^ 8'(y * 91);
    return row[7 - x];
  endfunction
  assign fm_bitmap = glyph_bit(fm_char, fm_xoffset[2:0], fm_yoffset[2:0]);
  function automatic bit visible(int h, int v);
    return h < HA && v < VA;
  endfunction
  function automatic int addr_of(int h, int v);
    return visible(h, v) ? (v / 8) * COLS + h / 8 : 0;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    ch = 0; cv = 0; fcount = 0; hrun = 0; vrun = 0;
    hold = '{h: 0, v: 0, vis: 0, hs: 1, vs: 1, hit: 0};
    e_rgb = 8'h00; e_act = 0; e_hs = 1; e_vs = 1;
  endtask
  task automatic step(bit pe);
    logic [8:0] nxt;
    logic [7:0] a_exp, a0 = 8'h18;
    bit a_chk = 0, b;
    pix_en = pe;
    #1;
    chk("text_addr", text_addr, addr_of(ch, cv));
    chk("frame_start", frame_start, rst_n && pe && ch == HT - 1 && cv == VT - 1);
    if (frame_start === 1'b1) fs_seen++;
    if (cv == 0 && ch == 7) chk("addr_7_0", text_addr, 0);
    if (cv == 0 && ch == 8) chk("addr_8_0", text_addr, 1);
    if (cv == 8 && ch == 0) chk("addr_0_8", text_addr, COLS);
    if (cv == VA - 1 && ch == HA - 1) chk("addr_last", text_addr, COLS * ROWS - 1);
    if (cv == 0 && ch == HA) chk("addr_hblank", text_addr, 0);
    if (cv == VA && ch == 0) chk("addr_vblank", text_addr, 0);
    @(posedge clk);
    nxt = mem[addr_of(ch, cv)];
    if (!rst_n) model_reset();
    else if (pe) begin
      // the cell in glyph lookup gets coloured with live colours and the current blink phase
      b = glyph_bit(ram_char, 3'(hold.h % 8), 3'(hold.v % 8)) ^ (hold.hit && (fcount / (1 << BL)) % 2 == 1);
      e_rgb = hold.vis ? (b ? fg_color : bg_color) : 8'h00;
      e_act = hold.vis; e_hs = hold.hs; e_vs = hold.vs;
      if (hold.vis && hold.v == 0 && hold.h < 7) begin
        a_exp = a0[7 - hold.h] ? fg_color : bg_color;
        a_chk = 1;
      end
      hold = '{h: ch, v: cv, vis: visible(ch, cv),
               hs: !(ch >= HA + HF && ch < HA + HF + HS), vs: !(cv >= VA + VF && cv < VA + VF + VS),
               hit: cursor_en && visible(ch, cv) && addr_of(ch, cv) == cursor_pos};
      if (ch == HT - 1 && cv == VT - 1) begin fcount++; frames++; end
      ch = (ch + 1) % HT;
      if (ch == 0) cv = (cv + 1) % VT;
    end
    ram_char = nxt;
    @(negedge clk);
    chk("rgb", rgb, e_rgb);
    chk("active", active, e_act);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    if (a_chk && !hold.hit) chk("glyph_A", rgb, a_exp);
    if (pe && rst_n) begin
      if (hsync === 1'b0) hrun++;
      else if (hrun > 0) begin chk("hsync_width", hrun, HS); hrun = 0; end
      if (vsync === 1'b0) vrun++;
      else if (vrun > 0) begin chk("vsync_width", vrun, VS * HT); vrun = 0; end
    end
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 9'($urandom);
    mem[0] = 9'h041;
    fg_color = 8'($urandom);
    bg_color = ~fg_color;
    cursor_en = 1;
    cursor_pos = 13'(COLS + 1);
    frames = 0; fs_seen = 0;
    rst_n = 0; pix_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_active", active, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_text_addr", text_addr, 0);
    model_reset();
    ram_char = mem[0];
    rst_n = 1;
    for (int i = 0; i < 2 * HT * VT; i++) step(i % 2 == 1);
    for (int i = 0; i < 20000 && frames < 5; i++) begin
      if (i % 997 == 0) begin fg_color = 8'($urandom); bg_color = ~fg_color; end
      step($urandom_range(0, 3) != 0);
    end
    chk("frames_run", frames, 5);
    while (!(ch == 30 && cv == 10)) step(1);
    rst_n = 0;
    step(1);
    chk("midrst_rgb", rgb, 8'h00);
    chk("midrst_active", active, 0);
    chk("midrst_hsync", hsync, 1);
    rst_n = 1;
    for (int i = 0; i < 9; i++) step(1);
    chk("restart_pos", ch, 9);
    for (int i = 0; i < 20000 && frames < 7; i++) step($urandom_range(0, 1) == 1);
    cursor_pos = 13'(COLS * ROWS);
    for (int i = 0; i < 20000 && frames < 8; i++) step($urandom_range(0, 3) != 0);
    chk("frame_start_count", fs_seen, frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
